beep_sequencer: RTL and testbench
=================================

# beep_sequencer

Sound-effect scheduler for the game audio path. It accepts one-shot effect requests from up to four game-logic sources, arbitrates them by fixed priority, and plays each effect's short note sequence. It sequences an effect by driving the 5-bit note code (`fre_num`) of the downstream tone divider, one note per step, with timed note durations and inter-note gaps. It owns all `fre_num` sequencing; game logic never drives notes directly.

## Interface
- `CLK_HZ`, 12000000: system clock frequency; documentation only, not used in logic.
- `TICK_DIV`, 120000: clock cycles per timing tick (10 ms at 12 MHz); legal range ≥ 2.
- `GAP_TICKS`, 2: ticks of silence inserted after every note; legal range ≥ 1.
- `clk`  in  1  system clock (12 MHz).
- `rst`  in  1  reset; synchronous, active-high.
- `req`  in  4  effect requests; bit i high for ≥1 cycle requests effect i; req[0] is highest priority.
- `mute`  in  1  forces `fre_num` to 0 without altering sequencing or timing.
- `fre_num`  out  5  note code to the tone divider; 0 = silence.
- `busy`  out  1  high while an effect is active (LOAD/PLAY/GAP).
- `grant`  out  4  one-hot, one-cycle pulse when effect i starts.
- `done`  out  1  one-cycle pulse when an effect completes naturally.

## Operation
- Effect ROM: fixed entries of (note, ticks), up to 4 steps each; a step with note 0, or step index 4, ends the effect.
  - E0 bounce: (12,3).
  - E1 score: (8,8) (10,8) (12,8) (15,16).
  - E2 miss: (10,10) (8,10) (5,20).
  - E3 start: (8,5) (8,5) (12,10).
- Pending register:
  - `pending[i]` sets on any cycle `req[i]` is high.
  - It clears when effect i is granted.
  - If set and clear coincide, set wins, so a re-request during its own grant cycle replays the effect afterward.
- FSM states: IDLE, LOAD, PLAY, GAP.
  - IDLE: go to LOAD when pending ≠ 0.
  - LOAD (1 cycle):
    - Select the lowest-index pending bit and latch it as `active`.
    - Pulse `grant`, clear that pending bit, set step=0, clear the tick and cycle counters.
    - Go to PLAY.
  - PLAY: `fre_num` = ROM note (0 if `mute`). After note-ticks × TICK_DIV cycles, go to GAP.
  - GAP: `fre_num` = 0. After GAP_TICKS × TICK_DIV cycles:
    - Increment step.
    - If the next step is an end marker or step = 4, pulse `done`, then go to LOAD if pending ≠ 0, else IDLE.
    - Otherwise go to PLAY.
- Preemption: in PLAY or GAP, if any pending bit has a lower index than `active`, go to LOAD on the next edge.
  - The aborted effect is discarded: no `done`, no resume.
  - Equal or lower priority requests wait in pending.
- Counters:
  - The cycle counter is ceil(log2(TICK_DIV)) bits and wraps at TICK_DIV−1 to generate ticks.
  - The tick counter is 5 bits.
  - Both counters restart at entry to every PLAY and GAP.

## Timing
- Reset values: `fre_num`=0, `busy`=0, `grant`=0, `done`=0, pending=0, state IDLE.
- `rst` mid-effect silences the output on the next edge and discards all pending requests.
- Latency from `req[i]` sampled high at edge E0:
  - Pending set at E0.
  - LOAD entered at E1 (`grant` and `busy` high during cycle E1–E2).
  - First note on `fre_num` from E2.
- Duration: PLAY lasts exactly ticks × TICK_DIV cycles; GAP lasts exactly GAP_TICKS × TICK_DIV cycles.
- `done` is high during the first cycle after the final GAP. `busy` is low that same cycle if nothing is pending.
  - Back-to-back effects insert one LOAD cycle; `busy` stays high throughout.
- Preemption: a higher-priority request sampled at edge E0 sets pending. LOAD follows at E1, and the new note appears from E2.
- `mute` acts combinationally from a registered state. It affects `fre_num` only; `busy`, `grant`, `done`, and counters are unchanged.
- All outputs are registered except the `mute` gating of `fre_num`.

## Test plan
All scenarios use TICK_DIV=4, GAP_TICKS=1.
- Reset: hold `rst` 3 cycles with `req`=4'hF → `fre_num`=0, `busy`=0, `grant`=0, `done`=0. No effect plays after release unless `req` is still high.
- Single effect: 1-cycle `req[1]` → `grant`=4'b0010 for 1 cycle, then `fre_num` sequence:
  - 8×32 cycles, 0×4;
  - 10×32, 0×4;
  - 12×32, 0×4;
  - 15×64, 0×4;
  - then `done` pulse and `busy`=0. Total of 176 cycles from first note to `done`.
- Arbitration: `req[2]` and `req[3]` in the same cycle → E2 (10,8,5 with gaps) plays first. After its `done`, one LOAD cycle, then E3 plays 8,8,12. Exactly two `done` pulses.
- Preemption: during E3's second note, pulse `req[0]` → `fre_num`=12 within 2 cycles for 12 cycles, then 0 for 4, then `done`. No `done` for E3; E3 does not resume.
- Mute: assert `mute` through E1 → `fre_num` stays 0 throughout; `grant`, `busy`, and the `done` cycle are identical to the unmuted run.
- Reset mid-play: assert `rst` during E2's first note with `req[0]` pending → all outputs 0 next cycle. No effect plays after release.

Source files
------------

// File: rtl/beep_sequencer_if.sv
// Effect request / note output bundle between game logic and the beep sequencer.
//   req     : per-effect one-shot requests, bit 0 is highest priority
//   mute    : silences fre_num without disturbing sequencing
//   fre_num : 5-bit note code to the tone divider, 0 = silence
//   busy    : an effect is being loaded or played
//   grant   : one-hot pulse when an effect starts
//   done    : pulse when an effect completes naturally
interface beep_sequencer_if;
  logic [3:0] req;
  logic       mute;
  logic [4:0] fre_num;
  logic       busy;
  logic [3:0] grant;
  logic       done;

  modport master (
    output req,
    output mute,
    input  fre_num,
    input  busy,
    input  grant,
    input  done
  );

  modport slave (
    input  req,
    input  mute,
    output fre_num,
    output busy,
    output grant,
    output done
  );
endinterface

// File: rtl/beep_sequencer.sv
// Sound-effect scheduler: latches effect requests, arbitrates by fixed
// priority (req[0] highest) and plays each effect's note sequence from a
// small ROM, with timed notes and silent gaps between them.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : beep_sequencer_if.slave (req/mute in, fre_num/busy/grant/done out)
module beep_sequencer #(
  parameter int unsigned CLK_HZ    = 12000000,
  parameter int unsigned TICK_DIV  = 120000,
  parameter int unsigned GAP_TICKS = 2
) (
  input  logic             clk,
  input  logic             rst,
  beep_sequencer_if.slave  bus
);

  localparam int unsigned N_EFF  = 4;
  localparam int unsigned EFF_W  = 2;
  localparam int unsigned STEP_W = 3;
  localparam int unsigned NOTE_W = 5;
  localparam int unsigned TICK_W = 5;
  localparam int unsigned CYC_W  = $clog2(TICK_DIV);
  localparam int unsigned ROM_W  = NOTE_W + TICK_W;

  // Reject parameter sets the timing scheme cannot represent.
  if (TICK_DIV < 2 || GAP_TICKS < 1 || TICK_DIV > CLK_HZ) begin : g_param_check
    $error("beep_sequencer: illegal TICK_DIV/GAP_TICKS/CLK_HZ combination");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP
  } state_e;

  // Effect ROM: {note, ticks}; a zero note or step 4 marks the end.
  function automatic logic [ROM_W-1:0] rom_entry(input logic [EFF_W-1:0]  eff,
                                                 input logic [STEP_W-1:0] step);
    logic [ROM_W-1:0] e;
    e = '0;
    unique case (eff)
      2'd0: begin
        case (step)
          3'd0:    e = {5'd12, 5'd3};
          default: e = '0;
        endcase
      end
      2'd1: begin
        case (step)
          3'd0:    e = {5'd8,  5'd8};
          3'd1:    e = {5'd10, 5'd8};
          3'd2:    e = {5'd12, 5'd8};
          3'd3:    e = {5'd15, 5'd16};
          default: e = '0;
        endcase
      end
      2'd2: begin
        case (step)
          3'd0:    e = {5'd10, 5'd10};
          3'd1:    e = {5'd8,  5'd10};
          3'd2:    e = {5'd5,  5'd20};
          default: e = '0;
        endcase
      end
      default: begin
        case (step)
          3'd0:    e = {5'd8,  5'd5};
          3'd1:    e = {5'd8,  5'd5};
          3'd2:    e = {5'd12, 5'd10};
          default: e = '0;
        endcase
      end
    endcase
    return e;
  endfunction

  state_e             state_q, state_d;
  logic [N_EFF-1:0]   pending_q, pending_d;
  logic [EFF_W-1:0]   active_q, active_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [NOTE_W-1:0]  fre_num_q, fre_num_d;
  logic               busy_q;
  logic [N_EFF-1:0]   grant_q, grant_d;
  logic               done_q, done_d;

  logic [EFF_W-1:0]   sel_idx;
  logic [N_EFF-1:0]   sel_oh;
  logic [N_EFF-1:0]   pend_clr;
  logic [STEP_W-1:0]  step_inc;
  logic [ROM_W-1:0]   rom_cur, rom_nxt, rom_d;
  logic [TICK_W-1:0]  last_tick;
  logic               tick_wrap, phase_end, end_next, preempt, go_load;

  // Lowest-index pending request wins arbitration.
  always_comb begin
    sel_idx = '0;
    for (int i = N_EFF - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = EFF_W'(i);
    end
    sel_oh = N_EFF'(4'b0001 << sel_idx);
  end

  // Phase timing: cycle counter makes ticks, tick counter measures the phase.
  always_comb begin
    step_inc  = step_q + 3'd1;
    rom_cur   = rom_entry(active_q, step_q);
    rom_nxt   = rom_entry(active_q, step_inc);
    end_next  = (step_inc == 3'd4) || (rom_nxt[ROM_W-1:TICK_W] == '0);
    last_tick = (state_q == S_PLAY) ? (rom_cur[TICK_W-1:0] - 5'd1)
                                    : TICK_W'(GAP_TICKS - 1);
    tick_wrap = (cyc_q == CYC_W'(TICK_DIV - 1));
    phase_end = tick_wrap && (tick_q == last_tick);
    // Any pending request above the active effect aborts it.
    preempt   = |(pending_q & N_EFF'((4'b0001 << active_q) - 4'b0001));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    step_d   = step_q;
    cyc_d    = '0;
    tick_d   = '0;
    grant_d  = '0;
    done_d   = 1'b0;
    pend_clr = '0;
    go_load  = 1'b0;

    unique case (state_q)
      S_IDLE: go_load = |pending_q;
      S_LOAD: state_d = S_PLAY;
      S_PLAY, S_GAP: begin
        if (preempt) begin
          go_load = 1'b1;
        end else if (!phase_end) begin
          cyc_d  = tick_wrap ? '0 : cyc_q + 1'b1;
          tick_d = tick_wrap ? tick_q + 5'd1 : tick_q;
        end else if (state_q == S_PLAY) begin
          state_d = S_GAP;
        end else if (end_next) begin
          done_d = 1'b1;
          if (|pending_q) go_load = 1'b1;
          else            state_d = S_IDLE;
        end else begin
          step_d  = step_inc;
          state_d = S_PLAY;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (go_load) begin
      state_d  = S_LOAD;
      active_d = sel_idx;
      step_d   = '0;
      grant_d  = sel_oh;
      pend_clr = sel_oh;
    end

    rom_d     = rom_entry(active_d, step_d);
    fre_num_d = (state_d == S_PLAY) ? rom_d[ROM_W-1:TICK_W] : '0;
    // A request coinciding with its own grant survives the clear.
    pending_d = (pending_q & ~pend_clr) | bus.req;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      active_q  <= '0;
      step_q    <= '0;
      cyc_q     <= '0;
      tick_q    <= '0;
      fre_num_q <= '0;
      busy_q    <= 1'b0;
      grant_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      step_q    <= step_d;
      cyc_q     <= cyc_d;
      tick_q    <= tick_d;
      fre_num_q <= fre_num_d;
      busy_q    <= (state_d != S_IDLE);
      grant_q   <= grant_d;
      done_q    <= done_d;
    end
  end

  // Mute gates the registered note without touching sequencing.
  assign bus.fre_num = bus.mute ? '0 : fre_num_q;
  assign bus.busy    = busy_q;
  assign bus.grant   = grant_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_beep_sequencer.sv
// Bench for beep_sequencer: directed scenarios followed by random requests,
// every cycle compared against a timeline-based reference model.
module tb_beep_sequencer;

  localparam int unsigned TD = 4;
  localparam int unsigned GT = 1;

  logic clk;
  logic rst;
  beep_sequencer_if bus ();

  beep_sequencer #(
    .CLK_HZ   (12000000),
    .TICK_DIV (TD),
    .GAP_TICKS(GT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc_no   = 0;

  int rom_n [4][4] = '{'{12, 0, 0, 0}, '{8, 10, 12, 15}, '{10, 8, 5, 0}, '{8, 8, 12, 0}};
  int rom_t [4][4] = '{'{3, 0, 0, 0},  '{8, 8, 8, 16},   '{10, 10, 20, 0}, '{5, 5, 10, 0}};

  // Reference model: phase 0 idle, 1 loading, 2 running a per-cycle note timeline.
  int         m_phase = 0;
  int         m_act   = 0;
  int         m_fre   = 0;
  logic [3:0] m_pend  = '0;
  logic [3:0] m_grant = '0;
  logic       m_done  = 1'b0;
  logic       m_busy  = 1'b0;
  int         tl[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc_no, got, exp);
    end
  endtask

  task automatic build_timeline(input int eff);
    tl.delete();
    for (int s = 0; s < 4; s++) begin
      if (rom_n[eff][s] == 0) break;
      repeat (rom_t[eff][s] * TD) tl.push_back(rom_n[eff][s]);
      repeat (GT * TD) tl.push_back(0);
    end
  endtask

  task automatic model_edge();
    logic [3:0] p;
    logic [3:0] clr;
    bit         do_load;
    if (rst) begin
      m_pend = '0; m_phase = 0; m_fre = 0; m_grant = '0; m_done = 1'b0;
      tl.delete();
    end else begin
      p = m_pend; clr = '0; do_load = 1'b0;
      m_grant = '0; m_done = 1'b0;
      case (m_phase)
        0: if (p != 0) do_load = 1'b1;
        1: begin
          build_timeline(m_act);
          m_fre = tl.pop_front();
          m_phase = 2;
        end
        default: begin
          if ((int'(p) % (1 << m_act)) != 0) do_load = 1'b1;
          else if (tl.size() == 0) begin
            m_done = 1'b1;
            if (p != 0) do_load = 1'b1;
            else begin m_phase = 0; m_fre = 0; end
          end else m_fre = tl.pop_front();
        end
      endcase
      if (do_load) begin
        for (int i = 3; i >= 0; i--) if (p[i]) m_act = i;
        m_grant = 4'(1 << m_act);
        clr = m_grant;
        m_phase = 1;
        m_fre = 0;
      end
      m_pend = (p & ~clr) | bus.req;
    end
    m_busy = (m_phase != 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc_no++;
    #1;
    check("fre_num", 16'(bus.fre_num), 16'(bus.mute ? 0 : m_fre));
    check("busy",    16'(bus.busy),    16'(m_busy));
    check("grant",   16'(bus.grant),   16'(m_grant));
    check("done",    16'(bus.done),    16'(m_done));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int k;
    int dones;
    int loud;
    bit seen;

    rst = 1'b1;
    bus.req = 4'hF;
    bus.mute = 1'b0;

    // Reset with all requests asserted, then release with requests idle.
    repeat (3) step();
    rst = 1'b0;
    bus.req = 4'h0;
    repeat (10) step();
    check("idle_after_reset", 16'(bus.busy), 16'd0);

    // Single effect E1 and its first-note-to-done length.
    bus.req = 4'b0010;
    step();
    bus.req = 4'h0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = (bus.fre_num != 0);
    end
    check("e1_first_note", 16'(bus.fre_num), 16'd8);
    k = 0;
    seen = 1'b0;
    while (k < 400 && !seen) begin
      step();
      k++;
      seen = bus.done;
    end
    check("e1_length", 16'(k), 16'd176);
    check("e1_busy_at_done", 16'(bus.busy), 16'd0);
    repeat (5) step();

    // Arbitration: E2 and E3 together, E2 first, two completions.
    bus.req = 4'b1100;
    step();
    bus.req = 4'h0;
    dones = 0;
    for (int i = 0; i < 320; i++) begin
      step();
      if (bus.done) dones++;
    end
    check("arb_done_count", 16'(dones), 16'd2);

    // Preemption of E3 during its second note by E0.
    bus.req = 4'b1000;
    step();
    bus.req = 4'h0;
    repeat (32) step();
    check("pre_note2", 16'(bus.fre_num), 16'd8);
    bus.req = 4'b0001;
    step();
    bus.req = 4'h0;
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.done) dones++;
    end
    check("pre_done_count", 16'(dones), 16'd1);
    check("pre_no_resume", 16'(bus.busy), 16'd0);

    // Muted E1: silent but otherwise identical.
    bus.mute = 1'b1;
    bus.req = 4'b0010;
    step();
    bus.req = 4'h0;
    dones = 0;
    loud = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (bus.done) dones++;
      if (bus.fre_num != 0) loud++;
    end
    check("mute_silent", 16'(loud), 16'd0);
    check("mute_done_count", 16'(dones), 16'd1);
    bus.mute = 1'b0;

    // Reset during E2's first note with E0 requested.
    bus.req = 4'b0100;
    step();
    bus.req = 4'h0;
    repeat (10) step();
    check("rst_mid_playing", 16'(bus.fre_num), 16'd10);
    rst = 1'b1;
    bus.req = 4'b0001;
    step();
    check("rst_mid_silent", 16'(bus.fre_num), 16'd0);
    rst = 1'b0;
    bus.req = 4'h0;
    repeat (30) step();
    check("rst_mid_idle", 16'(bus.busy), 16'd0);

    // Random requests, mute toggles and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 999) == 0);
      for (int b = 0; b < 4; b++) bus.req[b] = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 49) == 0) bus.mute = ~bus.mute;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
